router_pkt_receiver: RTL and testbench
======================================

Name: router_pkt_receiver

Overview:
Downstream consumer for one output port of the 1x3 router. It drains a router output FIFO through the vld_out/read_en/data_out interface and reassembles each packet: header, payload, then parity. It forwards header and payload bytes on a valid/ready byte stream, checks parity and address, and reports per-packet status. One instance is placed per router output port.

Parameters:
PORT_ID, 0, router port (0..2) this instance serves; expected value of header[1:0]
TIMEOUT, 32, idle cycles of vld_in mid-packet before abort (range 2..63)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
vld_in  in  1  router vld_outN (FIFO not empty)
data_in  in  8  router data_outN; valid on the cycle after read_en was asserted
read_en  out  1  router read_enN
m_data  out  8  forwarded byte (header, then payload)
m_valid  out  1  m_data valid
m_ready  in  1  sink accepts when m_valid and m_ready are both 1
m_last  out  1  marks the final forwarded byte of a packet
pkt_done  out  1  one-cycle pulse at end of packet (normal or abort)
pkt_err  out  1  parity or address mismatch; valid with pkt_done, held afterwards
pkt_abort  out  1  packet truncated by timeout; valid with pkt_done, held afterwards
pkt_len  out  6  header[7:2] of the last packet; held
pkt_addr  out  2  header[1:0] of the last packet; held
busy  out  1  1 while in HDR or BODY

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0, state IDLE, skid buffer empty, rd_pending=0, counters 0. A reset mid-packet discards any partial packet with no pkt_done pulse.
- Read timing: the router FIFO registers its data. A byte sampled while rd_pending=1 is the byte requested by the read_en of the previous cycle. rd_pending <= read_en.
- Read condition: read_en = vld_in & credit & want.
  - credit = (skid_count + rd_pending) < 2.
  - want = 1 in IDLE and HDR when no read is in flight. In BODY, want = (bytes_left - rd_pending) > 0.
  - read_en never depends combinationally on m_ready.
- States:
  - IDLE: on read_en, go to HDR.
  - HDR: when rd_pending, capture the header.
    - len=data_in[7:2], addr=data_in[1:0], acc=data_in.
    - bytes_left=len+1 (payload plus parity).
    - Push the header into the skid buffer with last=(len==0).
    - Go to BODY.
  - BODY: on each captured byte, bytes_left--.
    - If bytes_left>1 before the decrement: push the byte with last=(bytes_left==2) and set acc^=byte.
    - If bytes_left==1: the byte is the parity byte. It is not pushed. pkt_err <= (acc!=byte) | (addr!=PORT_ID). Go to DONE.
  - DONE: for one cycle, pkt_done=1, pkt_len/pkt_addr updated, pkt_abort=0. Then go to IDLE. No read_en is issued in DONE.
- Timeout: in BODY, idle_cnt increments on each cycle with vld_in=0 and rd_pending=0, and clears otherwise.
  - At idle_cnt==TIMEOUT-1, assert pkt_done with pkt_abort=1 and pkt_err=1, then go to IDLE.
  - Already-pushed bytes still drain; m_last is not synthesised.
  - This covers a router soft reset clearing the FIFO.
- Skid buffer: 2-entry FIFO of {last, data}.
  - m_valid = not empty. A push and a pop in the same cycle are both legal.
  - A push is guaranteed by credit never to overflow.
- Back-pressure: with m_ready=0 indefinitely, at most 2 bytes are buffered and reads stop.
  - The router soft-resets an unread FIFO after 30 cycles. That is the sink's responsibility and is documented as a system rule.
- len==0 packet: header (m_last=1), then parity; pkt_err computed with acc=header.
- Header arithmetic: bytes_left is 7 bits, so len=63 gives 64 with no overflow.

Decomposition:
- Package router_pkg:
  - header field constants: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0
  - state enum: IDLE, HDR, BODY, DONE
  - ROUTER_SOFT_RST_CYCLES=30
- Sub-module: router_rx_skid (2-deep, 9-bit-wide FIFO with count output). It is shared with future port stages.

Test Plan:
- Normal packet: header 0x0C, payload 0x11 0x22 0x33, parity 0x0C, m_ready=1.
  - Stream 0x0C, 0x11, 0x22, 0x33 (last on 0x33).
  - pkt_done pulse; pkt_err=0, pkt_len=3, pkt_addr=0.
- Bad parity: same packet with parity 0x0D -> pkt_err=1, pkt_abort=0, all 4 bytes still forwarded.
- Address check: PORT_ID=1, header 0x0C -> pkt_err=1 even with correct parity 0x0C.
- Back-pressure: hold m_ready=0 after the header.
  - At most 2 bytes buffered; read_en stays 0 while credit is exhausted.
  - Releasing m_ready delivers bytes in order with no loss or duplication.
- Timeout: header 0x10 (len 4), two payload bytes, then vld_in=0 for 32 cycles.
  - pkt_done with pkt_abort=1 and pkt_err=1; return to IDLE; the next packet is received cleanly.
- Zero-length and reset: header 0x04 (len 1)... followed by a len 0 header 0x00 and parity 0x00.
  - The 0x00 header is forwarded with m_last; pkt_err=0.
  - Assert rstn=0 mid-BODY of the next packet -> outputs 0, no pkt_done.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port receiver: header layout,
// receiver FSM states and the skid-buffer entry format.
package router_pkg;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    // Router clears an unread output FIFO after this many cycles; the sink must keep up.
    localparam int ROUTER_SOFT_RST_CYCLES = 30;
    localparam int SKID_W = 9;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} rx_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } skid_entry_t;
endpackage

// File: rtl/router_pkt_receiver_if.sv
// Router-side read port plus the forwarded valid/ready byte stream.
interface router_pkt_receiver_if;
    logic       vld_in;
    logic [7:0] data_in;
    logic       read_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (output vld_in, data_in, m_ready, input read_en, m_data, m_valid, m_last);
    modport slave  (input vld_in, data_in, m_ready, output read_en, m_data, m_valid, m_last);
endinterface

// File: rtl/router_rx_skid.sv
// Two-entry FIFO with occupancy output; push and pop may share a cycle.
module router_rx_skid
    import router_pkg::*;
#(
    parameter int W = SKID_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);
    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
endmodule

// File: rtl/router_pkt_receiver.sv
// Drains one router output FIFO, forwards header+payload on a byte stream,
// checks parity/address and reports per-packet status with a timeout abort.
module router_pkt_receiver
    import router_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    router_pkt_receiver_if.slave  rx,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic                  pkt_abort,
    output logic [5:0]            pkt_len,
    output logic [1:0]            pkt_addr,
    output logic                  busy
);
    rx_state_t   state_q, state_d;
    logic        rd_pending_q;
    logic [6:0]  bytes_left_q, bytes_left_d;
    logic [7:0]  acc_q, acc_d;
    logic [5:0]  hdr_len_q, hdr_len_d;
    logic [1:0]  hdr_addr_q, hdr_addr_d;
    logic [5:0]  idle_cnt_q, idle_cnt_d;
    logic        pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d, pkt_abort_q, pkt_abort_d;
    logic [5:0]  pkt_len_q, pkt_len_d;
    logic [1:0]  pkt_addr_q, pkt_addr_d;
    logic        credit, want, read_en, idle_cyc, timeout_hit, push, pop;
    skid_entry_t push_entry, pop_entry;
    logic [1:0]  skid_count;

    // Credit counts the in-flight read as occupied so the skid can never overflow.
    always_comb begin
        credit      = ({1'b0, skid_count} + {2'b0, rd_pending_q}) < 3'd2;
        idle_cyc    = !rx.vld_in && !rd_pending_q;
        timeout_hit = (state_q == BODY) && idle_cyc && (idle_cnt_q == 6'(TIMEOUT - 1));
        case (state_q)
            IDLE, HDR: want = !rd_pending_q;
            BODY:      want = bytes_left_q > {6'b0, rd_pending_q};
            default:   want = 1'b0;
        endcase
        read_en = rstn && rx.vld_in && credit && want;
    end

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        acc_d        = acc_q;
        hdr_len_d    = hdr_len_q;
        hdr_addr_d   = hdr_addr_q;
        idle_cnt_d   = 6'd0;
        pkt_done_d   = 1'b0;
        pkt_err_d    = pkt_err_q;
        pkt_abort_d  = pkt_abort_q;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        push         = 1'b0;
        push_entry   = '0;
        case (state_q)
            IDLE: if (read_en) state_d = HDR;
            HDR: if (rd_pending_q) begin
                hdr_len_d       = rx.data_in[LEN_MSB:LEN_LSB];
                hdr_addr_d      = rx.data_in[ADDR_MSB:ADDR_LSB];
                acc_d           = rx.data_in;
                bytes_left_d    = {1'b0, rx.data_in[LEN_MSB:LEN_LSB]} + 7'd1;
                push            = 1'b1;
                push_entry.last = (rx.data_in[LEN_MSB:LEN_LSB] == 6'd0);
                push_entry.data = rx.data_in;
                state_d         = BODY;
            end
            BODY: begin
                idle_cnt_d = idle_cyc ? idle_cnt_q + 6'd1 : 6'd0;
                if (rd_pending_q) begin
                    bytes_left_d = bytes_left_q - 7'd1;
                    if (bytes_left_q > 7'd1) begin
                        push            = 1'b1;
                        push_entry.last = (bytes_left_q == 7'd2);
                        push_entry.data = rx.data_in;
                        acc_d           = acc_q ^ rx.data_in;
                    end else begin
                        // Parity byte: consumed for the check, never forwarded.
                        pkt_done_d  = 1'b1;
                        pkt_err_d   = (acc_q != rx.data_in) || (hdr_addr_q != 2'(PORT_ID));
                        pkt_abort_d = 1'b0;
                        pkt_len_d   = hdr_len_q;
                        pkt_addr_d  = hdr_addr_q;
                        state_d     = DONE;
                    end
                end else if (timeout_hit) begin
                    pkt_done_d  = 1'b1;
                    pkt_err_d   = 1'b1;
                    pkt_abort_d = 1'b1;
                    pkt_len_d   = hdr_len_q;
                    pkt_addr_d  = hdr_addr_q;
                    idle_cnt_d  = 6'd0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rd_pending_q <= 1'b0;
            bytes_left_q <= 7'd0;
            acc_q        <= 8'd0;
            hdr_len_q    <= 6'd0;
            hdr_addr_q   <= 2'd0;
            idle_cnt_q   <= 6'd0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            pkt_abort_q  <= 1'b0;
            pkt_len_q    <= 6'd0;
            pkt_addr_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= read_en;
            bytes_left_q <= bytes_left_d;
            acc_q        <= acc_d;
            hdr_len_q    <= hdr_len_d;
            hdr_addr_q   <= hdr_addr_d;
            idle_cnt_q   <= idle_cnt_d;
            pkt_done_q   <= pkt_done_d;
            pkt_err_q    <= pkt_err_d;
            pkt_abort_q  <= pkt_abort_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
        end
    end

    router_rx_skid #(.W(SKID_W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .count     (skid_count)
    );

    assign pop        = rx.m_valid && rx.m_ready;
    assign rx.m_valid = (skid_count != 2'd0);
    assign rx.m_data  = pop_entry.data;
    assign rx.m_last  = pop_entry.last;
    assign rx.read_en = read_en;
    assign pkt_done   = pkt_done_q;
    assign pkt_err    = pkt_err_q;
    assign pkt_abort  = pkt_abort_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign busy       = (state_q == HDR) || (state_q == BODY);
endmodule

// File: tb/tb_router_pkt_receiver.sv
// Bench: router FIFO model feeds two receivers (port 0 and port 1); a
// packet-level model predicts the byte stream and per-packet status.
module tb_router_pkt_receiver;
    localparam int TIMEOUT = 32;
    typedef logic [7:0] byte_t;
    typedef struct {
        logic       err0, err1, abort;
        logic [5:0] len;
        logic [1:0] addr;
    } st_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    router_pkt_receiver_if ifc0();
    router_pkt_receiver_if ifc1();
    logic       done0, err0, abort0, busy0, done1, err1, abort1, busy1;
    logic [5:0] len0, len1;
    logic [1:0] addr0, addr1;

    assign ifc1.vld_in  = ifc0.vld_in;
    assign ifc1.data_in = ifc0.data_in;
    assign ifc1.m_ready = ifc0.m_ready;

    router_pkt_receiver #(.PORT_ID(0), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .rstn(rstn), .rx(ifc0.slave), .pkt_done(done0), .pkt_err(err0),
        .pkt_abort(abort0), .pkt_len(len0), .pkt_addr(addr0), .busy(busy0));
    router_pkt_receiver #(.PORT_ID(1), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rstn(rstn), .rx(ifc1.slave), .pkt_done(done1), .pkt_err(err1),
        .pkt_abort(abort1), .pkt_len(len1), .pkt_addr(addr1), .busy(busy1));

    int    checks = 0, failures = 0;
    byte_t rfifo[$];
    logic [8:0] exp_s[$];
    st_t   exp_st[$];
    logic [8:0] got_log[$];
    byte_t pay[$], empty_q[$];
    bit    gaps_en = 0;
    int    rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input byte_t hdr, input byte_t p[$], input bit bad);
        byte_t x;
        st_t   s;
        x = hdr;
        rfifo.push_back(hdr);
        exp_s.push_back({hdr[7:2] == 6'd0, hdr});
        foreach (p[i]) begin
            x ^= p[i];
            rfifo.push_back(p[i]);
            exp_s.push_back({i == p.size() - 1, p[i]});
        end
        rfifo.push_back(x ^ {7'd0, bad});
        s.err0 = bad || hdr[1:0] != 2'd0;
        s.err1 = bad || hdr[1:0] != 2'd1;
        s.abort = 1'b0; s.len = hdr[7:2]; s.addr = hdr[1:0];
        exp_st.push_back(s);
    endtask

    task automatic send_trunc(input byte_t hdr, input byte_t p[$]);
        st_t s;
        rfifo.push_back(hdr);
        exp_s.push_back({hdr[7:2] == 6'd0, hdr});
        foreach (p[i]) begin
            rfifo.push_back(p[i]);
            exp_s.push_back({1'b0, p[i]});
        end
        s.err0 = 1'b1; s.err1 = 1'b1; s.abort = 1'b1; s.len = hdr[7:2]; s.addr = hdr[1:0];
        exp_st.push_back(s);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (!(rfifo.size() == 0 && exp_s.size() == 0 && exp_st.size() == 0 && !busy0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_drain actual=timeout(%0d bytes,%0d status left) required=drained", tag, exp_s.size(), exp_st.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Router output FIFO: registered data, one byte per read_en.
    initial begin
        bit gate;
        int gap_run = 0;
        ifc0.vld_in = 1'b0; ifc0.data_in = 8'd0; ifc0.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                rfifo.delete();
                gap_run = 0;
                ifc0.vld_in <= 1'b0; ifc0.data_in <= 8'd0; ifc0.m_ready <= 1'b0;
            end else begin
                if (ifc0.read_en) begin
                    if (rfifo.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL read_on_empty actual=read_en=1 required=0");
                    end else ifc0.data_in <= rfifo.pop_front();
                end
                gate = !gaps_en || gap_run >= 3 || $urandom_range(0, 3) != 0;
                gap_run = gate ? 0 : gap_run + 1;
                ifc0.vld_in  <= gate && rfifo.size() != 0;
                ifc0.m_ready <= (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Compare process: stream bytes on accept, status on every pkt_done.
    initial begin
        logic [8:0] e;
        st_t s;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (ifc0.m_valid && ifc0.m_ready) begin
                    got_log.push_back({ifc0.m_last, ifc0.m_data});
                    if (exp_s.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL stream_extra actual=%0h required=none", {ifc0.m_last, ifc0.m_data});
                    end else begin
                        e = exp_s.pop_front();
                        chk("stream_last_data", {ifc0.m_last, ifc0.m_data}, e);
                    end
                end
                if (done0) begin
                    if (exp_st.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL pkt_done_extra actual=1 required=0");
                    end else begin
                        s = exp_st.pop_front();
                        chk("pkt_err", err0, s.err0);
                        chk("pkt_abort", abort0, s.abort);
                        chk("pkt_len", len0, s.len);
                        chk("pkt_addr", addr0, s.addr);
                        chk("p1_pkt_done", done1, 1);
                        chk("p1_pkt_err", err1, s.err1);
                        chk("p1_pkt_abort", abort1, s.abort);
                        chk("p1_pkt_len", len1, s.len);
                    end
                end else if (done1) begin
                    checks++; failures++;
                    $display("FAIL p1_pkt_done_extra actual=1 required=0");
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, reads, n;
        byte_t hdr;
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_read_en", ifc0.read_en, 0);
        chk("rst_m_valid", ifc0.m_valid, 0);
        chk("rst_m_data_last", {ifc0.m_last, ifc0.m_data}, 0);
        chk("rst_status", {done0, err0, abort0, len0, addr0, busy0}, 0);
        rstn = 1'b1;

        // Normal packet, pinned against literal values
        pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
        base = got_log.size();
        send_pkt(8'h0C, pay, 1'b0);
        wait_drain(200, "normal");
        chk("lit_nbytes", got_log.size() - base, 4);
        chk("lit_b0", got_log[base], 9'h00C);
        chk("lit_b1", got_log[base+1], 9'h011);
        chk("lit_b3", got_log[base+3], 9'h133);
        chk("lit_err", err0, 0);
        chk("lit_len", len0, 3);
        chk("lit_addr", addr0, 0);
        chk("lit_p1_addr_err", err1, 1);

        // Bad parity 0x0D
        base = got_log.size();
        send_pkt(8'h0C, pay, 1'b1);
        wait_drain(200, "badpar");
        chk("lit_badpar_err", err0, 1);
        chk("lit_badpar_abort", abort0, 0);
        chk("lit_badpar_nbytes", got_log.size() - base, 4);

        // Back-pressure: stall the sink before the packet arrives
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(byte_t'($urandom_range(0, 255)));
        send_pkt(8'h18, pay, 1'b0);
        reads = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifc0.read_en) reads++;
        end
        chk("bp_reads", reads, 2);
        chk("bp_m_valid", ifc0.m_valid, 1);
        chk("bp_head", {ifc0.m_last, ifc0.m_data}, 9'h018);
        rdy_mode = 0;
        wait_drain(200, "bp");

        // Timeout: len 4, two payload bytes, then the FIFO runs dry
        pay.delete(); pay.push_back(8'hA1); pay.push_back(8'hA2);
        send_trunc(8'h10, pay);
        wait_drain(300, "timeout");
        chk("to_abort", abort0, 1);
        chk("to_err", err0, 1);
        chk("to_len", len0, 4);
        chk("to_busy", busy0, 0);
        pay.delete(); pay.push_back(8'h3C);
        send_pkt(8'h04, pay, 1'b0);
        wait_drain(200, "after_to");
        chk("after_to_abort", abort0, 0);
        chk("after_to_err", err0, 0);

        // len 1 then len 0
        pay.delete(); pay.push_back(8'h5A);
        send_pkt(8'h04, pay, 1'b0);
        send_pkt(8'h00, empty_q, 1'b0);
        wait_drain(200, "zero");
        chk("zero_last_byte", got_log[got_log.size()-1], 9'h100);
        chk("zero_err", err0, 0);
        chk("zero_len", len0, 0);

        // Randomised traffic
        gaps_en = 1; rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            pay.delete();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) pay.push_back(byte_t'($urandom_range(0, 255)));
            hdr = {6'(n), ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(0, 3))};
            send_pkt(hdr, pay, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        wait_drain(8000, "random");
        gaps_en = 0; rdy_mode = 0;

        // Reset mid-BODY: partial packet vanishes without pkt_done
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(byte_t'(8'h70 + i));
        base = got_log.size();
        send_pkt(8'h28, pay, 1'b0);
        n = 0;
        while (got_log.size() < base + 3 && n < 100) begin @(negedge clk); n++; end
        chk("midpkt_reached", n < 100, 1);
        chk("midpkt_busy", busy0, 1);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        exp_s.delete(); exp_st.delete();
        chk("rst2_read_en", ifc0.read_en, 0);
        chk("rst2_m_valid", ifc0.m_valid, 0);
        chk("rst2_status", {done0, err0, abort0, len0, addr0, busy0}, 0);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst2_idle", busy0, 0);
        pay.delete(); pay.push_back(8'h01); pay.push_back(8'h02);
        send_pkt(8'h08, pay, 1'b0);
        wait_drain(200, "post_rst");
        chk("post_rst_len", len0, 2);
        chk("post_rst_err", err0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
